// File: rtl/instr_mem_loader.sv
// Byte-serial program loader feeding a byte-addressed instruction store.
// Frames are {word count, 4*N payload bytes, XOR checksum}; the core runs only after a good frame.
module instr_mem_loader #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_instr,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-2:0] words_loaded
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [8:0]       MAX_N    = 9'(DEPTH / 4);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(TIMEOUT - 1);

  logic [2:0]        state_q,  state_d;
  logic [ADDR_W-1:0] ptr_q,    ptr_d;
  logic [ADDR_W-2:0] nwords_q, nwords_d;
  logic [7:0]        csum_q,   csum_d;
  logic [CNT_W-1:0]  idle_q,   idle_d;
  logic [ADDR_W-2:0] wl_q,     wl_d;
  logic              done_q,   done_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_q [DEPTH];

  logic              loading;
  logic [ADDR_W:0]   last_idx;

  assign loading  = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign last_idx = {nwords_q, 2'b00} - (ADDR_W + 1)'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    nwords_d  = nwords_q;
    csum_d    = csum_q;
    idle_d    = idle_q;
    wl_d      = wl_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = in_data;

    // start wins over timeout and over any byte offered in the same cycle
    if (start) begin
      state_d = S_HDR;
      ptr_d   = '0;
      csum_d  = '0;
      wl_d    = '0;
      idle_d  = '0;
    end else if (loading && !in_valid) begin
      if (idle_q == IDLE_MAX) begin
        state_d = S_ERR;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + CNT_W'(1);
      end
    end else if (loading) begin
      idle_d = '0;
      case (state_q)
        S_HDR: begin
          ptr_d  = '0;
          csum_d = '0;
          wl_d   = '0;
          if ({1'b0, in_data} > MAX_N) begin
            state_d = S_ERR;
          end else begin
            nwords_d = (ADDR_W - 1)'(in_data);
            state_d  = (in_data == 8'd0) ? S_CSUM : S_DATA;
          end
        end
        S_DATA: begin
          mem_we = 1'b1;
          csum_d = csum_q ^ in_data;
          ptr_d  = ptr_q + ADDR_W'(1);
          if (ptr_q[1:0] == 2'b11) begin
            wl_d = wl_q + (ADDR_W - 1)'(1);
          end
          if ({1'b0, ptr_q} == last_idx) begin
            state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (in_data == csum_q) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      nwords_q <= '0;
      csum_q   <= '0;
      idle_q   <= '0;
      wl_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      nwords_q <= nwords_d;
      csum_q   <= csum_d;
      idle_q   <= idle_d;
      wl_q     <= wl_d;
      done_q   <= done_d;
    end
  end

  // Store is never cleared; rst only suppresses a write offered on the same edge.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  logic [ADDR_W-1:0] fa0, fa1, fa2, fa3;

  assign fa0 = fetch_addr;
  assign fa1 = fetch_addr + ADDR_W'(1);
  assign fa2 = fetch_addr + ADDR_W'(2);
  assign fa3 = fetch_addr + ADDR_W'(3);

  assign in_ready     = loading;
  assign cpu_run      = (state_q == S_RUN);
  assign load_err     = (state_q == S_ERR);
  assign load_done    = done_q;
  assign words_loaded = wl_q;
  assign fetch_instr  = cpu_run ? {mem_q[fa0], mem_q[fa1], mem_q[fa2], mem_q[fa3]} : 32'h0;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader: a frame-level reference model predicts every output
// each cycle, and directed scenarios pin key values with hand-computed literals.
module tb_instr_mem_loader;

  localparam int DEPTH   = 256;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 1024;
  localparam int MAXW    = DEPTH / 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic [31:0]       fetch_instr;
  logic              cpu_run;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W-2:0] words_loaded;

  always #5 clk = ~clk;

  instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .fetch_addr(fetch_addr), .fetch_instr(fetch_instr),
    .cpu_run(cpu_run), .load_done(load_done), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0 idle, 1 receiving a frame, 2 running, 3 error.
  int           m_mode = 0;
  byte unsigned m_frame[$];
  int           m_idle = 0;
  bit           m_done = 1'b0;
  logic [7:0]   m_mem[DEPTH];
  bit           m_known[DEPTH];
  bit           chk_en = 1'b0;
  logic [7:0]   pay[DEPTH];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int m_words();
    int n, k;
    if (m_frame.size() < 2) return 0;
    n = m_frame[0];
    k = m_frame.size() - 1;
    if (k > 4 * n) k = 4 * n;
    return k / 4;
  endfunction

  function automatic void model_step();
    int n, sz;
    logic [7:0] x;
    if (rst) begin
      m_mode = 0;
      m_frame.delete();
      m_idle = 0;
      m_done = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (start) begin
      m_mode = 1;
      m_frame.delete();
      m_idle = 0;
    end else if (m_mode == 1) begin
      if (!in_valid) begin
        m_idle++;
        if (m_idle == TIMEOUT) m_mode = 3;
      end else begin
        m_idle = 0;
        m_frame.push_back(in_data);
        n  = m_frame[0];
        sz = m_frame.size();
        if (sz == 1) begin
          if (n > MAXW) m_mode = 3;
        end else if (sz - 2 < 4 * n) begin
          m_mem[sz - 2]   = in_data;
          m_known[sz - 2] = 1'b1;
        end else begin
          x = 8'h00;
          for (int i = 1; i <= 4 * n; i++) x = x ^ m_frame[i];
          if (in_data == x) begin
            m_mode = 2;
            m_done = 1'b1;
          end else begin
            m_mode = 3;
          end
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    logic [31:0] exp_i, msk;
    int a;
    if (chk_en) begin
      check("in_ready", {31'b0, in_ready}, {31'b0, (m_mode == 1)});
      check("cpu_run", {31'b0, cpu_run}, {31'b0, (m_mode == 2)});
      check("load_err", {31'b0, load_err}, {31'b0, (m_mode == 3)});
      check("load_done", {31'b0, load_done}, {31'b0, m_done});
      check("words_loaded", {25'b0, words_loaded}, m_words());
      exp_i = 32'h0;
      msk   = 32'hFFFF_FFFF;
      if (m_mode == 2) begin
        for (int b = 0; b < 4; b++) begin
          a = (int'(fetch_addr) + b) % DEPTH;
          if (m_known[a]) exp_i[31 - 8 * b -: 8] = m_mem[a];
          else            msk[31 - 8 * b -: 8]   = 8'h00;
        end
      end
      check("fetch_instr", fetch_instr & msk, exp_i & msk);
    end
  end

  task automatic tick(bit s, bit v, logic [7:0] d);
    start      = s;
    in_valid   = v;
    in_data    = d;
    fetch_addr = ADDR_W'($urandom);
    @(posedge clk);
    model_step();
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send(logic [7:0] b, int maxstall);
    repeat ($urandom_range(0, maxstall)) tick(1'b0, 1'b0, 8'($urandom));
    tick(1'b0, 1'b1, b);
  endtask

  task automatic send_frame(int n, bit good, int maxstall, int abort_at);
    logic [7:0] x;
    x = 8'h00;
    tick(1'b1, 1'($urandom), 8'($urandom));
    send(8'(n), maxstall);
    if (n > MAXW) return;
    for (int i = 0; i < 4 * n; i++) begin
      if (i == abort_at) return;
      pay[i] = 8'($urandom);
      x = x ^ pay[i];
      send(pay[i], maxstall);
    end
    send(good ? x : (x ^ 8'(1 + $urandom_range(0, 254))), maxstall);
  endtask

  task automatic fetch_at(int a, logic [31:0] exp, string name);
    fetch_addr = ADDR_W'(a);
    #1;
    check(name, fetch_instr, exp);
  endtask

  initial begin
    logic [7:0] x;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; fetch_addr = '0;
    tick(1'b0, 1'b0, 8'h00);
    chk_en = 1'b1;
    tick(1'b0, 1'b1, 8'h55);
    rst = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_cpu_run", {31'b0, cpu_run}, 32'd0);
    check("rst_load_err", {31'b0, load_err}, 32'd0);
    check("rst_words", {25'b0, words_loaded}, 32'd0);

    // Single-word frame: 8C 20 00 04 XORs to A8.
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h01);
    tick(1'b0, 1'b1, 8'h8C);
    tick(1'b0, 1'b1, 8'h20);
    tick(1'b0, 1'b1, 8'h00);
    tick(1'b0, 1'b1, 8'h04);
    tick(1'b0, 1'b1, 8'hA8);
    check("t1_done", {31'b0, load_done}, 32'd1);
    check("t1_run", {31'b0, cpu_run}, 32'd1);
    check("t1_words", {25'b0, words_loaded}, 32'd1);
    fetch_at(0, 32'h8C20_0004, "t1_fetch0");
    tick(1'b0, 1'b0, 8'h00);
    check("t1_done_pulse", {31'b0, load_done}, 32'd0);

    // Bad checksum, then recovery.
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h01);
    tick(1'b0, 1'b1, 8'h8C);
    tick(1'b0, 1'b1, 8'h20);
    tick(1'b0, 1'b1, 8'h00);
    tick(1'b0, 1'b1, 8'h04);
    tick(1'b0, 1'b1, 8'h29);
    check("t2_err", {31'b0, load_err}, 32'd1);
    check("t2_run", {31'b0, cpu_run}, 32'd0);
    fetch_at(0, 32'h0, "t2_fetch_zero");
    tick(1'b1, 1'b0, 8'h00);
    check("t2_err_clear", {31'b0, load_err}, 32'd0);
    tick(1'b0, 1'b1, 8'h01);
    tick(1'b0, 1'b1, 8'h8C);
    tick(1'b0, 1'b1, 8'h20);
    tick(1'b0, 1'b1, 8'h00);
    tick(1'b0, 1'b1, 8'h04);
    tick(1'b0, 1'b1, 8'hA8);
    check("t2_rerun", {31'b0, cpu_run}, 32'd1);

    // Oversized header.
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h41);
    check("t3_err", {31'b0, load_err}, 32'd1);
    check("t3_words", {25'b0, words_loaded}, 32'd0);

    // Full store and wrapping fetch.
    send_frame(64, 1'b1, 2, -1);
    check("t4_run", {31'b0, cpu_run}, 32'd1);
    check("t4_words", {25'b0, words_loaded}, 32'd64);
    fetch_at(254, {pay[254], pay[255], pay[0], pay[1]}, "t4_wrap");

    // Stall after three payload bytes.
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h04);
    tick(1'b0, 1'b1, 8'h11);
    tick(1'b0, 1'b1, 8'h22);
    tick(1'b0, 1'b1, 8'h33);
    repeat (TIMEOUT - 1) tick(1'b0, 1'b0, 8'h00);
    check("t5_no_err_yet", {31'b0, load_err}, 32'd0);
    tick(1'b0, 1'b0, 8'h00);
    check("t5_timeout", {31'b0, load_err}, 32'd1);

    // Gaps one short of the limit never time out.
    tick(1'b1, 1'b0, 8'h00);
    x = 8'h00;
    repeat (TIMEOUT - 1) tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h02);
    for (int i = 1; i <= 8; i++) begin
      x = x ^ 8'(17 * i);
      repeat (TIMEOUT - 1) tick(1'b0, 1'b0, 8'h00);
      tick(1'b0, 1'b1, 8'(17 * i));
    end
    repeat (TIMEOUT - 1) tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, x);
    check("t5_toggle_run", {31'b0, cpu_run}, 32'd1);

    // start from RUN, then reset mid-payload.
    tick(1'b1, 1'b0, 8'h00);
    check("t6_run_drop", {31'b0, cpu_run}, 32'd0);
    tick(1'b0, 1'b1, 8'h08);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 8'(8'hA0 + i));
    rst = 1'b1;
    tick(1'b0, 1'b1, 8'hFF);
    rst = 1'b0;
    check("t6_in_ready", {31'b0, in_ready}, 32'd0);
    check("t6_load_err", {31'b0, load_err}, 32'd0);
    check("t6_load_done", {31'b0, load_done}, 32'd0);
    check("t6_words", {25'b0, words_loaded}, 32'd0);
    fetch_at(0, 32'h0, "t6_fetch_zero");
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h01);
    x = 8'h00;
    for (int i = 0; i < 4; i++) begin
      x = x ^ 8'(8'hC0 + i);
      tick(1'b0, 1'b1, 8'(8'hC0 + i));
    end
    tick(1'b0, 1'b1, x);
    check("t6_run", {31'b0, cpu_run}, 32'd1);
    fetch_at(0, 32'hC0C1_C2C3, "t6_fetch0");
    fetch_at(4, 32'hA466_7788, "t6_fetch4");
    fetch_at(8, {pay[8], pay[9], pay[10], pay[11]}, "t6_fetch8");

    // Empty frame.
    send_frame(0, 1'b1, 1, -1);
    check("t7_empty_run", {31'b0, cpu_run}, 32'd1);
    check("t7_empty_words", {25'b0, words_loaded}, 32'd0);

    // Randomized frames: sizes, bad checksums, aborts, stalls.
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(0, 70);
      send_frame(n, ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 2),
                 ($urandom_range(0, 5) == 0) ? $urandom_range(0, 4 * n) : -1);
      repeat ($urandom_range(1, 6)) tick(1'b0, 1'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
